// File: rtl/torus_pkg.sv
// Shared types and constants for the torus ray-march responder.
// All datapath values are Q2.14 / world-unit signed 16-bit quantities.
package torus_pkg;
   localparam int QW = 16;
   typedef logic signed [QW-1:0] q_t;
   typedef q_t [2:0] vec_t;  // [0]=x, [1]=y, [2]=z

   localparam q_t WORLD_ONE   = 16'sd256;
   localparam q_t R2_DEF      = 2 * WORLD_ONE;
   localparam q_t R1_DEF      = WORLD_ONE;
   localparam q_t HIT_EPS_DEF = 16'sd8;

   typedef enum logic [1:0] {IDLE, MARCH, SHADE} state_t;

   function automatic q_t sat16(input logic signed [31:0] v);
      if (v > 32'sd32767)       return 16'sh7FFF;
      else if (v < -32'sd32768) return 16'sh8000;
      else                      return q_t'(v);
   endfunction
endpackage

// File: rtl/torus_sdf.sv
// Combinational torus signed-distance estimate using the octagonal
// length approximation len(a,b) = M - M/8 + m/2 (16-bit wrapping).
module torus_sdf
   import torus_pkg::*;
#(
   parameter q_t R2 = R2_DEF,
   parameter q_t R1 = R1_DEF
) (
   input  q_t x,
   input  q_t y,
   input  q_t z,
   output q_t d
);
   function automatic q_t len2(input q_t a, input q_t b);
      q_t aa, bb, mx, mn;
      aa = a[QW-1] ? -a : a;
      bb = b[QW-1] ? -b : b;
      if (aa > bb) begin
         mx = aa;
         mn = bb;
      end else begin
         mx = bb;
         mn = aa;
      end
      return mx - (mx >>> 3) + (mn >>> 1);
   endfunction

   q_t rxy;
   assign rxy = len2(x, y) - R2;
   assign d   = len2(rxy, z) - R1;
endmodule

// File: rtl/torus_march.sv
// Ray-query responder: sphere-traces the torus for STEPS cycles, then
// one shade cycle producing registered hit/light and a done pulse.
module torus_march
   import torus_pkg::*;
#(
   parameter int STEPS   = 6,
   parameter q_t R2      = R2_DEF,
   parameter q_t R1      = R1_DEF,
   parameter q_t HIT_EPS = HIT_EPS_DEF,
   parameter int LSHIFT  = 6,
   parameter int GAIN    = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  q_t   pxin,
   input  q_t   pyin,
   input  q_t   pzin,
   input  q_t   rxin,
   input  q_t   ryin,
   input  q_t   rzin,
   input  q_t   lxin,
   input  q_t   lyin,
   input  q_t   lzin,
   output logic hit,
   output q_t   light,
   output logic busy,
   output logic done
);
   localparam int CW = $clog2(STEPS + 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   vec_t            p_q, r_q, l_q, p_nxt, p_prb;
   q_t              d_q, d_m, d_l;
   logic            hit_f;
   logic signed [31:0] diff, shl;

   torus_sdf #(.R2(R2), .R1(R1)) u_sdf_march (
      .x(p_q[0]), .y(p_q[1]), .z(p_q[2]), .d(d_m)
   );
   torus_sdf #(.R2(R2), .R1(R1)) u_sdf_probe (
      .x(p_prb[0]), .y(p_prb[1]), .z(p_prb[2]), .d(d_l)
   );

   // Step uses this cycle's distance; product is truncated after the shift.
   for (genvar i = 0; i < 3; i++) begin : g_axis
      logic signed [31:0] prod;
      assign prod     = $signed(r_q[i]) * $signed(d_m);
      assign p_nxt[i] = p_q[i] + q_t'(prod >>> 14);
      assign p_prb[i] = p_q[i] + ($signed(l_q[i]) >>> LSHIFT);
   end

   assign diff = {{16{d_l[QW-1]}}, d_l} - {{16{d_q[QW-1]}}, d_q};
   assign shl  = diff <<< GAIN;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         p_q   <= '0;
         r_q   <= '0;
         l_q   <= '0;
         d_q   <= '0;
         hit_f <= 1'b0;
         hit   <= 1'b0;
         light <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         // A new query pre-empts whatever is in flight, including SHADE.
         if (start) begin
            p_q   <= {pzin, pyin, pxin};
            r_q   <= {rzin, ryin, rxin};
            l_q   <= {lzin, lyin, lxin};
            hit_f <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MARCH;
         end else begin
            case (state)
               MARCH: begin
                  if (!hit_f) begin
                     d_q <= d_m;
                     if (d_m < HIT_EPS) hit_f <= 1'b1;
                     else               p_q   <= p_nxt;
                  end
                  if (cnt == CW'(STEPS - 1)) begin
                     cnt   <= '0;
                     state <= SHADE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               SHADE: begin
                  hit   <= hit_f;
                  light <= hit_f ? sat16(shl) : '0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_torus_march.sv
// Directed bench for torus_march: vector table plus restart, streaming,
// saturation (LSHIFT=0 instance) and asynchronous-reset sequences.
module tb_torus_march;
   import torus_pkg::*;

   localparam int STEPS = 6;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   q_t pxin = '0, pyin = '0, pzin = '0;
   q_t rxin = '0, ryin = '0, rzin = '0;
   q_t lxin = '0, lyin = '0, lzin = '0;
   logic hit, busy, done, hit_s, busy_s, done_s;
   q_t   light, light_s;

   torus_march #(.STEPS(STEPS)) dut (
      .clk(clk), .rst(rst), .start(start),
      .pxin(pxin), .pyin(pyin), .pzin(pzin),
      .rxin(rxin), .ryin(ryin), .rzin(rzin),
      .lxin(lxin), .lyin(lyin), .lzin(lzin),
      .hit(hit), .light(light), .busy(busy), .done(done)
   );

   torus_march #(.STEPS(STEPS), .LSHIFT(0)) dut_sat (
      .clk(clk), .rst(rst), .start(start),
      .pxin(pxin), .pyin(pyin), .pzin(pzin),
      .rxin(rxin), .ryin(ryin), .rzin(rzin),
      .lxin(lxin), .lyin(lyin), .lzin(lzin),
      .hit(hit_s), .light(light_s), .busy(busy_s), .done(done_s)
   );

   always #5 clk = ~clk;

   typedef struct {
      q_t px, py, pz, rx, ry, rz, lx, ly, lz;
      logic ehit;
      int   elight;
      int   elight_s;
   } vec_rec_t;

   vec_rec_t tv[5];
   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_rec_t v);
      pxin = v.px; pyin = v.py; pzin = v.pz;
      rxin = v.rx; ryin = v.ry; rzin = v.rz;
      lxin = v.lx; lyin = v.ly; lzin = v.lz;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_hit"}, int'(hit), 0);
      chk({tag, "_light"}, int'(light), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
   endtask

   // Start at E0, expect no done through E6, result and done at E7.
   task automatic run(input vec_rec_t v, input string tag);
      apply(v);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy0"}, int'(busy), 1);
      chk({tag, "_done0"}, int'(done), 0);
      for (int k = 1; k <= STEPS; k++) begin
         tick();
         chk($sformatf("%s_done_e%0d", tag, k), int'(done), 0);
      end
      tick();
      chk({tag, "_done"}, int'(done), 1);
      chk({tag, "_done_s"}, int'(done_s), 1);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_hit"}, int'(hit), int'(v.ehit));
      chk({tag, "_light"}, int'(light), v.elight);
      chk({tag, "_light_sat"}, int'(light_s), v.elight_s);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      tv[0] = '{16'sd512, 16'sd0, -16'sd1024, 16'sd0, 16'sd0, 16'sd16384,
                16'sd0, 16'sd0, -16'sd4096, 1'b1, 7168, 32767};
      tv[1] = '{16'sd0, 16'sd0, -16'sd1024, 16'sd0, 16'sd0, 16'sd16384,
                16'sd0, 16'sd0, -16'sd4096, 1'b0, 0, 0};
      tv[2] = '{16'sd512, 16'sd0, -16'sd1024, 16'sd0, 16'sd0, 16'sd16384,
                16'sd0, 16'sd0, 16'sd4096, 1'b1, -7168, 32767};
      tv[3] = '{16'sd0, 16'sd512, -16'sd1024, 16'sd0, 16'sd0, 16'sd16384,
                16'sd0, 16'sd0, -16'sd4096, 1'b1, 7168, 32767};
      tv[4] = '{16'sd512, 16'sd0, -16'sd1024, 16'sd0, 16'sd0, 16'sd16384,
                16'sd0, 16'sd0, -16'sd32768, 1'b1, 32767, 32767};

      // Reset state, then quiet idle after release.
      #2 rst = 1'b1;
      tick();
      tick();
      chk_zero("rst");
      rst = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk_zero("idle");

      // Table, queries back to back.
      for (int i = 0; i < 5; i++) run(tv[i], $sformatf("vec%0d", i));
      tick();
      chk("vec_done_one_cycle", int'(done), 0);

      // Restart: hit at E0, miss at E3, prior result (hit, 32767) holds.
      apply(tv[0]);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      apply(tv[1]);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rst_e3_done", int'(done), 0);
      for (int k = 4; k <= 9; k++) begin
         tick();
         chk($sformatf("restart_done_e%0d", k), int'(done), 0);
         chk($sformatf("restart_hold_hit_e%0d", k), int'(hit), 1);
         chk($sformatf("restart_hold_light_e%0d", k), int'(light), 32767);
      end
      tick();
      chk("restart_done", int'(done), 1);
      chk("restart_hit", int'(hit), 0);
      chk("restart_light", int'(light), 0);

      // Streaming: 16 alternating hit/miss queries every 8 cycles.
      for (int q = 0; q < 16; q++) run(tv[q % 2], $sformatf("stream%0d", q));
      tick();
      chk("stream_done_one_cycle", int'(done), 0);

      // Asynchronous reset mid-march after a hit result is showing.
      run(tv[0], "prereset");
      apply(tv[0]);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("prereset_busy", int'(busy), 1);
      chk("prereset_hit", int'(hit), 1);
      #2 rst = 1'b1;
      #1;
      chk_zero("async_rst");
      tick();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      chk_zero("post_rst");
      chk("post_rst_light_sat", int'(light_s), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
